// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: ALU opcodes, MULDIV funct codes,
// and the iterative multiply/divide unit state type.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_NOR    = 4'd5;
  localparam logic [3:0] ALU_SLT    = 4'd6;
  localparam logic [3:0] ALU_SLTU   = 4'd7;
  localparam logic [3:0] ALU_SLL    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_SRA    = 4'd10;
  localparam logic [3:0] ALU_LUI    = 4'd11;
  localparam logic [3:0] ALU_MULDIV = 4'd12;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the MULDIV instructions that occupy the iterative unit.
  function automatic logic is_long_muldiv(input logic [3:0] op, input logic [5:0] funct);
    return (op == ALU_MULDIV) && ((funct == FN_MULTU) || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle, owning the HI/LO architectural registers.
module muldiv_iter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,      // 0: MULTU, 1: DIVU
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  logic [4:0]  r_cnt;
  logic        r_op;
  logic [31:0] r_opnd;   // multiplicand or divisor
  logic [31:0] r_upper;  // partial product high half or partial remainder
  logic [31:0] r_lower;  // remaining multiplier bits or dividend bits turning into quotient
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_mul_sum;
  logic [32:0] w_rem_sh;
  logic [31:0] w_upper_nx;
  logic [31:0] w_lower_nx;

  // One iteration step for whichever operation is in flight.
  always_comb begin
    w_mul_sum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : 33'd0);
    w_rem_sh  = {r_upper, r_lower[31]};
    if (r_op) begin
      // Remainder stays below 2^32 after a successful subtract, so 32 bits suffice.
      if (w_rem_sh >= {1'b0, r_opnd}) begin
        w_upper_nx = w_rem_sh[31:0] - r_opnd;
        w_lower_nx = {r_lower[30:0], 1'b1};
      end else begin
        w_upper_nx = w_rem_sh[31:0];
        w_lower_nx = {r_lower[30:0], 1'b0};
      end
    end else begin
      w_upper_nx = w_mul_sum[32:1];
      w_lower_nx = {w_mul_sum[0], r_lower[31:1]};
    end
  end

  // Unit needs the pipeline held: on the start cycle and until the last step.
  always_comb begin
    busy = 1'b0;
    if (r_state == MD_IDLE) busy = start;
    else                    busy = (r_cnt != 5'd31);
  end

  // FSM, counter, working registers and HI/LO; cancel overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_opnd  <= '0;
      r_upper <= '0;
      r_lower <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (cancel) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_opnd  <= op ? b : a;
            r_lower <= op ? a : b;
            r_upper <= '0;
            r_cnt   <= '0;
            r_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_upper <= w_upper_nx;
          r_lower <= w_lower_nx;
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            // Both operations leave {HI,LO} in {upper,lower} after the final step.
            r_hi    <= w_upper_nx;
            r_lo    <= w_lower_nx;
            r_state <= MD_IDLE;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, HI/LO access via the iterative
// multiply/divide unit, stall generation and the EX/MEM pipeline register.
module ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] R1_i,
  input  logic [31:0] R2_i,
  input  logic [31:0] Imm_i,
  input  logic [31:0] c0Data_i,
  input  logic [4:0]  Shamt_i,
  input  logic [3:0]  ALUOp_i,
  input  logic [5:0]  Funct_i,
  input  logic [5:0]  Rt_i,
  input  logic [5:0]  Rd_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrcA_i,
  input  logic        ALUSrcB_i,
  input  logic        RegDst_i,
  input  logic        mfc0_i,
  input  logic [1:0]  RegData_i,
  input  logic        Cancel_EX,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] ALURes_o,
  output logic [31:0] R2_o,
  output logic [5:0]  WReg_o,
  output logic        RegWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [1:0]  RegData_o
);

  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic [31:0] w_alu;
  logic [31:0] w_res;
  logic [5:0]  w_wreg;
  logic        w_long;
  logic        w_md_busy;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  assign w_opa  = ALUSrcA_i ? {27'b0, Shamt_i} : R1_i;
  assign w_opb  = ALUSrcB_i ? Imm_i : R2_i;
  assign w_long = is_long_muldiv(ALUOp_i, Funct_i);
  assign w_res  = mfc0_i ? c0Data_i : w_alu;
  assign w_wreg = RegDst_i ? Rd_i : Rt_i;

  muldiv_iter u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (w_long),
    .op     (Funct_i == FN_DIVU),
    .a      (R1_i),
    .b      (R2_i),
    .cancel (Cancel_EX),
    .busy   (w_md_busy),
    .hi     (w_hi),
    .lo     (w_lo)
  );

  assign stall_o = w_md_busy && !Cancel_EX;

  // ALU result, including HI/LO reads for MFHI/MFLO.
  always_comb begin
    w_alu = '0;
    case (ALUOp_i)
      ALU_ADD:  w_alu = w_opa + w_opb;
      ALU_SUB:  w_alu = w_opa - w_opb;
      ALU_AND:  w_alu = w_opa & w_opb;
      ALU_OR:   w_alu = w_opa | w_opb;
      ALU_XOR:  w_alu = w_opa ^ w_opb;
      ALU_NOR:  w_alu = ~(w_opa | w_opb);
      ALU_SLT:  w_alu = {31'b0, ($signed(w_opa) < $signed(w_opb))};
      ALU_SLTU: w_alu = {31'b0, (w_opa < w_opb)};
      ALU_SLL:  w_alu = w_opb << w_opa[4:0];
      ALU_SRL:  w_alu = w_opb >> w_opa[4:0];
      ALU_SRA:  w_alu = $unsigned($signed(w_opb) >>> w_opa[4:0]);
      ALU_LUI:  w_alu = {w_opb[15:0], 16'h0000};
      ALU_MULDIV: begin
        case (Funct_i)
          FN_MFHI: w_alu = w_hi;
          FN_MFLO: w_alu = w_lo;
          default: w_alu = '0;
        endcase
      end
      default:  w_alu = '0;
    endcase
  end

  // EX/MEM register: bubble while stalled or cancelled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o       <= '0;
      ALURes_o   <= '0;
      R2_o       <= '0;
      WReg_o     <= '0;
      RegWrite_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      RegData_o  <= '0;
    end else if (Cancel_EX || w_md_busy) begin
      pc_o       <= '0;
      ALURes_o   <= '0;
      R2_o       <= '0;
      WReg_o     <= '0;
      RegWrite_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      RegData_o  <= '0;
    end else begin
      pc_o       <= pc_i;
      ALURes_o   <= w_res;
      R2_o       <= R2_i;
      WReg_o     <= w_wreg;
      RegWrite_o <= RegWrite_i && !w_long;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      RegData_o  <= RegData_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: instruction-level model with per-cycle comparison.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, R1_i, R2_i, Imm_i, c0Data_i;
  logic [4:0]  Shamt_i;
  logic [3:0]  ALUOp_i;
  logic [5:0]  Funct_i, Rt_i, Rd_i;
  logic        RegWrite_i, MemRead_i, MemWrite_i, ALUSrcA_i, ALUSrcB_i, RegDst_i, mfc0_i;
  logic [1:0]  RegData_i;
  logic        Cancel_EX;
  logic        stall_o;
  logic [31:0] pc_o, ALURes_o, R2_o;
  logic [5:0]  WReg_o;
  logic        RegWrite_o, MemRead_o, MemWrite_o;
  logic [1:0]  RegData_o;

  ex_stage u_dut (
    .clk(clk), .rst(rst),
    .pc_i(pc_i), .R1_i(R1_i), .R2_i(R2_i), .Imm_i(Imm_i), .c0Data_i(c0Data_i),
    .Shamt_i(Shamt_i), .ALUOp_i(ALUOp_i), .Funct_i(Funct_i), .Rt_i(Rt_i), .Rd_i(Rd_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i), .RegDst_i(RegDst_i), .mfc0_i(mfc0_i),
    .RegData_i(RegData_i), .Cancel_EX(Cancel_EX), .stall_o(stall_o),
    .pc_o(pc_o), .ALURes_o(ALURes_o), .R2_o(R2_o), .WReg_o(WReg_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .RegData_o(RegData_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, r1, r2, imm, c0;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic [5:0]  funct, rt, rd;
    logic        rw, mr, mw, srca, srcb, regdst, mfc0;
    logic [1:0]  rdata;
  } ins_t;

  typedef struct packed {
    logic [31:0] pc, res, r2;
    logic [5:0]  wreg;
    logic        rw, mr, mw;
    logic [1:0]  rdata;
  } out_t;

  int   total = 0;
  int   bad   = 0;
  int   stall_cnt = 0;
  logic chk_en = 1'b0;
  logic m_stall;
  out_t m_out, m_next;
  logic [31:0] m_hi, m_lo;
  logic [31:0] pc_ctr = 32'h0000_0400;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_long(input ins_t i);
    return (i.aluop == 4'd12) && (i.funct == 6'h19 || i.funct == 6'h1B);
  endfunction

  // Architectural result of one instruction, given the model HI/LO.
  function automatic out_t model(input ins_t i);
    logic [31:0] a, b, r;
    logic [63:0] w;
    out_t o;
    a = i.srca ? {27'b0, i.shamt} : i.r1;
    b = i.srcb ? i.imm : i.r2;
    r = 32'd0;
    case (i.aluop)
      4'd0:  r = a + b;
      4'd1:  r = a + ~b + 32'd1;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a & ~b;
      4'd6:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (longint'({32'b0, a}) < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      4'd8:  begin w = {32'b0, b} * (64'd1 << a[4:0]); r = w[31:0]; end
      4'd9:  r = b / (32'd1 << a[4:0]);
      4'd10: begin w = {{32{b[31]}}, b} >> a[4:0]; r = w[31:0]; end
      4'd11: r = b * 32'd65536;
      4'd12: r = (i.funct == 6'h10) ? m_hi : (i.funct == 6'h12) ? m_lo : 32'd0;
      default: r = 32'd0;
    endcase
    o.pc    = i.pc;
    o.res   = i.mfc0 ? i.c0 : r;
    o.r2    = i.r2;
    o.wreg  = i.regdst ? i.rd : i.rt;
    o.rw    = i.rw && !is_long(i);
    o.mr    = i.mr;
    o.mw    = i.mw;
    o.rdata = i.rdata;
    return o;
  endfunction

  task automatic drive(input ins_t i);
    pc_i = i.pc; R1_i = i.r1; R2_i = i.r2; Imm_i = i.imm; c0Data_i = i.c0;
    Shamt_i = i.shamt; ALUOp_i = i.aluop; Funct_i = i.funct; Rt_i = i.rt; Rd_i = i.rd;
    RegWrite_i = i.rw; MemRead_i = i.mr; MemWrite_i = i.mw; ALUSrcA_i = i.srca;
    ALUSrcB_i = i.srcb; RegDst_i = i.regdst; mfc0_i = i.mfc0; RegData_i = i.rdata;
  endtask

  // One cycle: expected stall this cycle and what EX/MEM holds after the edge.
  task automatic step(input logic st, input out_t nxt);
    m_stall = st;
    m_next  = nxt;
    @(posedge clk);
    #1;
    m_out = m_next;
  endtask

  // Present one instruction until it leaves EX; cancel_k is the EX cycle
  // index (0 = first) at which Cancel_EX is pulsed, or -1 for none.
  task automatic run(input ins_t i, input int cancel_k);
    out_t o;
    int n;
    logic [63:0] p;
    logic [31:0] nh, nl;
    i.pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    drive(i);
    o = model(i);
    n = is_long(i) ? 33 : 1;
    nh = m_hi; nl = m_lo;
    if (is_long(i)) begin
      if (i.funct == 6'h19) begin
        p = {32'b0, i.r1} * {32'b0, i.r2};
        nh = p[63:32]; nl = p[31:0];
      end else if (i.r2 == 32'd0) begin
        nh = i.r1; nl = 32'hFFFF_FFFF;
      end else begin
        nh = i.r1 % i.r2; nl = i.r1 / i.r2;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (k == cancel_k) begin
        Cancel_EX = 1'b1;
        step(1'b0, '0);
        Cancel_EX = 1'b0;
        return;
      end
      if (k < n - 1) step(1'b1, '0);
      else           step(1'b0, o);
    end
    m_hi = nh;
    m_lo = nl;
  endtask

  function automatic ins_t mk(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2);
    ins_t i;
    i = '0;
    i.aluop = op; i.r1 = r1; i.r2 = r2; i.rw = 1'b1;
    i.rt = 6'd3; i.rd = 6'd7; i.rdata = 2'd1;
    return i;
  endfunction

  function automatic ins_t md(input logic [5:0] fn, input logic [31:0] r1, input logic [31:0] r2);
    ins_t i;
    i = mk(4'd12, r1, r2);
    i.funct = fn; i.regdst = 1'b1;
    return i;
  endfunction

  // Per-cycle comparison of every output and HI/LO against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_o) stall_cnt++;
      chk("stall",    stall_o,        m_stall);
      chk("pc",       pc_o,           m_out.pc);
      chk("alures",   ALURes_o,       m_out.res);
      chk("r2",       R2_o,           m_out.r2);
      chk("wreg",     WReg_o,         m_out.wreg);
      chk("regwrite", RegWrite_o,     m_out.rw);
      chk("memread",  MemRead_o,      m_out.mr);
      chk("memwrite", MemWrite_o,     m_out.mw);
      chk("regdata",  RegData_o,      m_out.rdata);
      chk("hi",       u_dut.u_md.hi,  m_hi);
      chk("lo",       u_dut.u_md.lo,  m_lo);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    rst = 1'b1; Cancel_EX = 1'b0; drive('0);
    m_stall = 1'b0; m_out = '0; m_next = '0; m_hi = '0; m_lo = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst0_pc",  pc_o, 0);
    chk("rst0_res", ALURes_o, 0);
    chk("rst0_rw",  RegWrite_o, 0);
    chk("rst0_hi",  u_dut.u_md.hi, 0);
    chk("rst0_lo",  u_dut.u_md.lo, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // ALU patterns
    run(mk(4'd0, 32'd5, 32'hFFFF_FFFD), -1);
    chk("add_lit", ALURes_o, 32'd2);
    run(mk(4'd6, 32'hFFFF_FFFF, 32'd1), -1);
    chk("slt_lit", ALURes_o, 32'd1);
    run(mk(4'd7, 32'hFFFF_FFFF, 32'd1), -1);
    run(mk(4'd1, 32'd3, 32'd5), -1);
    run(mk(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF), -1);
    run(mk(4'd3, 32'hA000_0001, 32'h0500_0010), -1);
    run(mk(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F), -1);
    run(mk(4'd5, 32'h1234_5678, 32'h0000_FFFF), -1);
    t = mk(4'd10, 32'd0, 32'h8000_0000); t.srca = 1'b1; t.shamt = 5'd4;
    run(t, -1);
    chk("sra_lit", ALURes_o, 32'hF800_0000);
    t = mk(4'd8, 32'd0, 32'h0000_0001); t.srca = 1'b1; t.shamt = 5'd31;
    run(t, -1);
    run(mk(4'd9, 32'd7, 32'h8000_00F0), -1);
    t = mk(4'd11, 32'd0, 32'd0); t.srcb = 1'b1; t.imm = 32'h0000_1234;
    run(t, -1);
    chk("lui_lit", ALURes_o, 32'h1234_0000);
    t = mk(4'd0, 32'h1000_0000, 32'hDEAD_BEEF); t.srcb = 1'b1; t.imm = 32'h10;
    t.mw = 1'b1; t.rw = 1'b0; t.rdata = 2'd2; t.regdst = 1'b1;
    run(t, -1);
    t = mk(4'd0, 32'h40, 32'd0); t.mr = 1'b1; t.rdata = 2'd3;
    run(t, -1);

    // MULTU max x max
    stall_cnt = 0;
    run(md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), -1);
    chk("mul_stall_cycles", stall_cnt, 32);
    chk("mul_hi_lit", u_dut.u_md.hi, 32'hFFFF_FFFE);
    chk("mul_lo_lit", u_dut.u_md.lo, 32'd1);
    chk("mul_rw_lit", RegWrite_o, 0);

    // DIVU then immediate HI/LO reads
    run(md(6'h1B, 32'd100, 32'd7), -1);
    run(md(6'h12, 32'd0, 32'd0), -1);
    chk("mflo_div_lit", ALURes_o, 32'd14);
    run(md(6'h10, 32'd0, 32'd0), -1);
    chk("mfhi_div_lit", ALURes_o, 32'd2);
    run(md(6'h1B, 32'd9, 32'd0), -1);
    run(md(6'h12, 32'd0, 32'd0), -1);
    chk("mflo_div0_lit", ALURes_o, 32'hFFFF_FFFF);
    run(md(6'h10, 32'd0, 32'd0), -1);
    chk("mfhi_div0_lit", ALURes_o, 32'd9);
    run(md(6'h00, 32'd3, 32'd4), -1);

    // Cancel at cnt=10 (EX cycle 11), then restart
    stall_cnt = 0;
    run(md(6'h19, 32'd7, 32'd6), 11);
    chk("cancel_stall_cycles", stall_cnt, 11);
    chk("cancel_bubble_pc", pc_o, 0);
    chk("cancel_hi_lit", u_dut.u_md.hi, 32'd9);
    chk("cancel_lo_lit", u_dut.u_md.lo, 32'hFFFF_FFFF);
    run(md(6'h19, 32'd7, 32'd6), -1);
    run(md(6'h12, 32'd0, 32'd0), -1);
    chk("restart_lo_lit", ALURes_o, 32'd42);

    // MFC0
    t = mk(4'd0, 32'd1, 32'd2); t.mfc0 = 1'b1; t.c0 = 32'h1234_5678;
    t.rd = 6'd12; t.regdst = 1'b1;
    run(t, -1);
    chk("mfc0_res_lit", ALURes_o, 32'h1234_5678);
    chk("mfc0_wreg_lit", WReg_o, 6'd12);

    // Cancel of a plain instruction
    run(mk(4'd0, 32'd11, 32'd22), 0);

    // Asynchronous reset mid-run
    run(mk(4'd0, 32'd100, 32'd23), -1);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_pc",  pc_o, 0);
    chk("rst_mid_res", ALURes_o, 0);
    chk("rst_mid_rw",  RegWrite_o, 0);
    chk("rst_mid_hi",  u_dut.u_md.hi, 0);
    chk("rst_mid_lo",  u_dut.u_md.lo, 0);
    m_out = '0; m_hi = '0; m_lo = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    run(md(6'h12, 32'd0, 32'd0), -1);
    run(mk(4'd0, 32'd0, 32'd0), -1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the interrupt-capable pipelined CPU. It consumes the ID/EX pipeline register outputs, performs the ALU operation, and runs unsigned multiply and divide on an iterative unit that writes the HI/LO registers. It stalls the front end while that unit is busy and registers its results into the EX/MEM pipeline register that feeds the MEM stage.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`, `R1_i`, `R2_i`, `Imm_i`, `c0Data_i`  in  32 each  outputs of ID/EX.
- `Shamt_i`  in  5  shift amount.
- `ALUOp_i`  in  4  ALU operation.
- `Funct_i`  in  6  instruction funct field.
- `Rt_i`, `Rd_i`  in  6 each  destination register candidates; bit 5 set selects a c0 register.
- `RegWrite_i`, `MemRead_i`, `MemWrite_i`, `ALUSrcA_i`, `ALUSrcB_i`, `RegDst_i`, `mfc0_i`  in  1 each  control bits.
- `RegData_i`  in  2  write-back source select.
- `Cancel_EX`  in  1  flush of the instruction in EX, driven by the interrupt logic.
- `stall_o`  out  1  combinational; holds PC, IF/ID and ID/EX.
- `pc_o`, `ALURes_o`, `R2_o`  out  32 each  EX/MEM outputs: pc, result, and store data.
- `WReg_o`  out  6  destination register.
- `RegWrite_o`, `MemRead_o`, `MemWrite_o`  out  1 each  EX/MEM control bits.
- `RegData_o`  out  2  write-back source select.

## Operation
- Operand A is `{27'b0, Shamt_i}` when `ALUSrcA_i` is set, otherwise `R1_i`.
- Operand B is `Imm_i` when `ALUSrcB_i` is set, otherwise `R2_i`.
- ALUOp encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
  - 8 SLL B by A[4:0], 9 SRL, 10 SRA, 11 LUI (B<<16).
  - 12 MULDIV; the operation is selected by funct.
- All arithmetic is modulo 2^32. Overflow is ignored.
- MULDIV funct values:
  - 0x19 MULTU: {HI,LO} = R1 × R2.
  - 0x1B DIVU: LO = R1 / R2, HI = R1 % R2.
  - 0x10 MFHI: result = HI.
  - 0x12 MFLO: result = LO.
  - Any other funct gives result 0.
- Result select: `c0Data_i` when `mfc0_i` is set, otherwise the ALU/HI/LO value.
- `WReg` is `Rd_i` when `RegDst_i` is set, otherwise `Rt_i`.
- A MULTU or DIVU instruction leaves the stage with RegWrite forced to 0.
- Iterative unit FSM states are IDLE and BUSY, with a 5-bit counter `cnt`.
  - IDLE: a MULTU or DIVU present and `Cancel_EX` low causes the unit to latch operands, set cnt=0, assert `stall_o`, and go to BUSY.
  - BUSY: performs one shift-add step (multiply) or one restoring step (divide) per cycle, then cnt++. `stall_o` stays high while cnt<31.
  - At cnt==31, `stall_o` drops and the final step completes. On that edge HI/LO are written, the instruction enters EX/MEM, and the unit returns to IDLE.
- DIVU by zero gives LO=0xFFFF_FFFF and HI=dividend. It is not trapped.
- `Cancel_EX` high in any state:
  - EX/MEM loads a bubble.
  - The FSM goes to IDLE and HI/LO are unchanged.
  - `stall_o` drops in that same cycle.

## Timing
- Reset is asynchronous. It clears:
  - every EX/MEM output to 0;
  - HI and LO to 0;
  - FSM state to IDLE and `cnt` to 0.
- Non-MULDIV instructions, MFHI and MFLO have a latency of one cycle: inputs at edge N appear on the outputs after edge N+1.
- MULTU and DIVU:
  - `stall_o` is high for exactly 32 consecutive cycles (the start cycle plus cnt 0..30).
  - The instruction occupies EX for 33 cycles and reaches EX/MEM on the 33rd edge.
- While `stall_o` is high, EX/MEM loads a bubble every cycle (all outputs 0).
- A MFHI or MFLO directly after a MULTU or DIVU sees the new HI/LO value. No forwarding is required, because the unit has stalled until HI/LO are written.
- `Cancel_EX` takes priority over start, step and completion.

## Structure
- A shared package `cpu_pkg` holds:
  - the ALUOp codes;
  - the funct constants MULTU, DIVU, MFHI and MFLO;
  - the FSM state enum.
- Sub-module `muldiv_iter` holds the FSM, counter, shift registers and HI/LO. It exposes start, op, a, b, cancel, busy, hi and lo.
- The ALU and the EX/MEM register stay in `ex_stage`.

## Test plan
- Reset asserted mid-run: every output is 0 and HI=LO=0 immediately, without waiting for a clock edge.
- ADD with R1=5, R2=0xFFFF_FFFD: ALURes_o=2 after one edge; SLT with R1=-1, R2=1 gives ALURes_o=1.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:
  - `stall_o` is high for exactly 32 cycles;
  - then HI=0xFFFF_FFFE and LO=1;
  - RegWrite_o=0.
- DIVU 100/7 followed by MFLO and MFHI: MFLO gives 14 and MFHI gives 2. DIVU 9/0 gives LO=0xFFFF_FFFF and HI=9.
- MULTU 7×6 with `Cancel_EX` pulsed at cnt=10: stall drops that cycle, EX/MEM holds a bubble, and HI/LO keep their prior value. A restart then completes with LO=42.
- MFC0 with c0Data_i=0x1234_5678 and Rd_i=6'd12, RegDst=1: ALURes_o=0x1234_5678 and WReg_o=12.
